// File: rtl/gray_fifo_wptr.sv
`default_nettype none
// ============================================================================
// Module  : gray_fifo_wptr (with PrefixAnd, IncGrayC)
// Brief   : Write-side pointer stage of a dual-clock FIFO: Gray/binary write
//           pointer, read-pointer synchroniser, registered Full/Level/Overflow.
// Rev     : 1.0  initial release
// ============================================================================

// Prefix AND: o_y[i] = &i_x[i:0]. SPEED 0 is a ripple chain, otherwise a
// log-depth Kogge-Stone tree.
module PrefixAnd #(
    parameter int N     = 4,
    parameter int SPEED = 2
) (
    input  logic [N-1:0] i_x,
    output logic [N-1:0] o_y
);
    generate
        if (SPEED == 0) begin : g_ripple
            logic [N-1:0] w_chain;
            assign w_chain[0] = i_x[0];
            for (genvar i = 1; i < N; i++) begin : g_bit
                assign w_chain[i] = w_chain[i-1] & i_x[i];
            end
            assign o_y = w_chain;
        end else begin : g_tree
            localparam int c_levels = (N > 1) ? $clog2(N) : 1;
            logic [c_levels:0][N-1:0] w_lvl;
            assign w_lvl[0] = i_x;
            for (genvar s = 0; s < c_levels; s++) begin : g_stage
                for (genvar i = 0; i < N; i++) begin : g_bit
                    if (i >= (1 << s)) begin : g_comb
                        assign w_lvl[s+1][i] = w_lvl[s][i] & w_lvl[s][i-(1<<s)];
                    end else begin : g_pass
                        assign w_lvl[s+1][i] = w_lvl[s][i];
                    end
                end
            end
            assign o_y = w_lvl[c_levels];
        end
    endgenerate
endmodule

// Gray incrementer: even parity toggles bit 0, odd parity toggles the bit
// left of the lowest set bit (the MSB when that bit is one of the top two).
module IncGrayC #(
    parameter int N     = 5,
    parameter int SPEED = 2
) (
    input  logic [N-1:0] i_a,
    input  logic         i_ci,
    output logic [N-1:0] o_z
);
    logic         w_par;
    logic [N-2:0] w_low_zero;
    logic [N-1:0] w_zb;
    logic [N-1:0] w_tog;

    PrefixAnd #(
        .N     (N - 1),
        .SPEED (SPEED)
    ) u_pfx (
        .i_x (~i_a[N-2:0]),
        .o_y (w_low_zero)
    );

    assign w_par = ^i_a;
    // w_zb[k]: every bit below position k is zero
    assign w_zb  = {w_low_zero, 1'b1};

    assign w_tog[0]   = ~w_par;
    assign w_tog[N-1] = w_par & (w_zb[N-1] | (i_a[N-2] & w_zb[N-2]));
    generate
        for (genvar i = 1; i < N - 1; i++) begin : g_mid
            assign w_tog[i] = w_par & i_a[i-1] & w_zb[i-1];
        end
    endgenerate

    assign o_z = i_a ^ (w_tog & {N{i_ci}});
endmodule

module gray_fifo_wptr #(
    parameter int width       = 4,
    parameter int speed       = 2,
    parameter int sync_stages = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Push,
    input  logic [width:0]   RPtrAsync,
    output logic [width:0]   WPtr,
    output logic [width-1:0] WAddr,
    output logic             WEn,
    output logic             Full,
    output logic [width:0]   Level,
    output logic             Overflow
);
    localparam int c_pw = width + 1;

    logic [sync_stages-1:0][width:0] r_sync;
    logic [width:0] r_bptr;
    logic [width:0] r_gptr;
    logic [width:0] r_level;
    logic           r_full;
    logic           r_ovf;

    logic           w_accept;
    logic [width:0] w_bnext;
    logic [width:0] w_gnext;
    logic [width:0] w_rsync;
    logic [width:0] w_rbin;
    logic [width:0] w_full_pat;

    function automatic logic [width:0] gray2bin(input logic [width:0] g);
        logic [width:0] b;
        b[width] = g[width];
        for (int i = width - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_accept = Push & ~r_full;
    assign w_bnext  = r_bptr + {{width{1'b0}}, w_accept};
    assign w_rsync  = r_sync[sync_stages-1];
    assign w_rbin   = gray2bin(w_rsync);

    IncGrayC #(
        .N     (c_pw),
        .SPEED (speed)
    ) u_inc (
        .i_a  (r_gptr),
        .i_ci (w_accept),
        .o_z  (w_gnext)
    );

    // Full when the write pointer is exactly one lap ahead of the read pointer
    generate
        if (width == 1) begin : g_full_w1
            assign w_full_pat = ~w_rsync;
        end else begin : g_full_wn
            assign w_full_pat = {~w_rsync[width:width-1], w_rsync[width-2:0]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= RPtrAsync;
            for (int i = 1; i < sync_stages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bptr  <= '0;
            r_gptr  <= '0;
            r_full  <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_bptr  <= w_bnext;
            r_gptr  <= w_gnext;
            r_full  <= (w_gnext == w_full_pat);
            r_level <= w_bnext - w_rbin;
            if (Push && r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign WPtr     = r_gptr;
    assign WAddr    = r_bptr[width-1:0];
    assign WEn      = w_accept;
    assign Full     = r_full;
    assign Level    = r_level;
    assign Overflow = r_ovf;
endmodule
`default_nettype wire
